// File: rtl/aes_sd_ctrl.sv
// aes_sd_ctrl: request/response sequencer for the word-serial AES core.
// It runs the core's init window, loads four words, collects four result words, and has a watchdog.
module aes_sd_ctrl #(
    parameter int         INIT_CYCLES  = 88,
    parameter int         START_CYCLES = 2,
    parameter int         TIMEOUT      = 200,
    parameter logic [7:0] DONE_CODE    = 8'h10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_text,
    output logic         rsp_err,
    output logic         busy,
    output logic         core_start,
    output logic         core_sel,
    output logic [31:0]  core_data_in,
    input  logic [31:0]  core_data_out,
    input  logic [7:0]   core_signals
);
    // One shared phase counter, wide enough for the longest phase
    localparam int M1   = INIT_CYCLES > TIMEOUT ? INIT_CYCLES : TIMEOUT;
    localparam int M2   = M1 > START_CYCLES ? M1 : START_CYCLES;
    localparam int CMAX = M2 > 4 ? M2 : 4;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [2:0] {INIT_START, INIT_WAIT, IDLE, START, LOAD, WAIT, READ, RESP} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [127:0]   text_q, result;
    logic           sel_q, err_q, done;

    assign done = core_signals == DONE_CODE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT_START;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            INIT_START: if (cnt == CW'(START_CYCLES - 1)) begin state_n = INIT_WAIT; cnt_n = '0; end
            INIT_WAIT:  if (cnt == CW'(INIT_CYCLES - 1)) begin state_n = IDLE; cnt_n = '0; end
            IDLE: begin
                cnt_n = '0;
                if (req_valid) state_n = START;
            end
            START:      if (cnt == CW'(START_CYCLES - 1)) begin state_n = LOAD; cnt_n = '0; end
            LOAD:       if (cnt == CW'(3)) begin state_n = WAIT; cnt_n = '0; end
            // Done wins over the watchdog when both land on the same cycle
            WAIT: begin
                if (done) begin
                    state_n = READ;
                    cnt_n   = '0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end
            end
            READ:       if (cnt == CW'(2)) begin state_n = RESP; cnt_n = '0; end
            RESP: begin
                cnt_n = '0;
                if (rsp_ready) state_n = IDLE;
            end
            default: begin
                state_n = INIT_START;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready    = state == IDLE;
        rsp_valid    = state == RESP;
        busy         = state != IDLE;
        core_start   = state == INIT_START || state == START;
        core_data_in = state != LOAD ? 32'h0 :
                       cnt == CW'(0) ? text_q[127:96] :
                       cnt == CW'(1) ? text_q[95:64] :
                       cnt == CW'(2) ? text_q[63:32] : text_q[31:0];
    end

    assign rsp_text = result;
    assign rsp_err  = err_q;
    assign core_sel = sel_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            text_q <= '0;
            sel_q  <= 1'b1;
            result <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                text_q <= req_text;
                sel_q  <= req_mode;
            end
            if (state == WAIT && done) begin
                result <= {core_data_out, 96'h0};
                err_q  <= 1'b0;
            end else if (state == WAIT && cnt == CW'(TIMEOUT - 1)) begin
                result <= '0;
                err_q  <= 1'b1;
            end
            // Lower 96 bits shift in words 1..3 so word 3 lands in [31:0]
            if (state == READ) result <= {result[127:96], result[63:0], core_data_out};
        end
    end
endmodule

// File: tb/tb_aes_sd_ctrl.sv
// tb_aes_sd_ctrl: directed self-checking bench for aes_sd_ctrl.
// The core is played by the bench, which drives done codes and result words on fixed cycles.
module tb_aes_sd_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_mode = 1'b0;
    logic [127:0] req_text = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_text;
    logic         rsp_err;
    logic         busy;
    logic         core_start;
    logic         core_sel;
    logic [31:0]  core_data_in;
    logic [31:0]  core_data_out = '0;
    logic [7:0]   core_signals = '0;

    int checks = 0;
    int errors = 0;

    aes_sd_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_err(rsp_err),
        .busy(busy), .core_start(core_start), .core_sel(core_sel), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_signals(core_signals)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_core_start", core_start, 1);
        chk("rst_core_sel", core_sel, 1);
        chk("rst_core_data_in", core_data_in, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_text", rsp_text, 0);
        chk("rst_busy", busy, 1);
    endtask

    // Counts release edges until req_ready rises; optionally plays a stale done during init
    task automatic init_window(input bit late_done);
        int st = 1, rr = 0, din_bad = 0, rv = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (core_start) st++;
            if (core_data_in != 0) din_bad++;
            if (rsp_valid) rv++;
            if (req_ready && rr == 0) rr = n;
            if (late_done) begin
                core_signals  = (n >= 3 && n < 7) ? 8'h10 : 8'h00;
                core_data_out = (n >= 3 && n < 7) ? 32'hdeadbeef : 32'h0;
            end
        end
        chk("init_start_cycles", st, 2);
        chk("init_ready_cycle", rr, 90);
        chk("init_data_in_zero", din_bad, 0);
        chk("init_no_rsp", rv, 0);
    endtask

    // From IDLE: handshake, start pulse and four load words; leaves the DUT in its first WAIT cycle
    task automatic send_req(input logic [127:0] text, input logic mode, input bit inj);
        req_text  = text;
        req_mode  = mode;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("start_0", core_start, 1);
        chk("sel_mode", core_sel, mode);
        chk("busy_op", busy, 1);
        chk("req_ready_op", req_ready, 0);
        tick();
        chk("start_1", core_start, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("load_start_low", core_start, 0);
            chk("load_word", core_data_in, text[127-32*k -: 32]);
            core_signals = (inj && k == 0) ? 8'h10 : 8'h00;
        end
        tick();
        chk("wait_data_in", core_data_in, 0);
        chk("wait_no_rsp", rsp_valid, 0);
    endtask

    // Done on the current cycle, then three more words; ends in RESP
    task automatic core_reply(input logic [127:0] words);
        core_signals  = 8'h10;
        core_data_out = words[127:96];
        tick();
        core_signals  = 8'h00;
        core_data_out = words[95:64];
        chk("read_no_rsp", rsp_valid, 0);
        tick();
        core_data_out = words[63:32];
        tick();
        core_data_out = words[31:0];
        chk("read_last_no_rsp", rsp_valid, 0);
        tick();
        core_data_out = 32'h0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_text", rsp_text, words);
        chk("rsp_err", rsp_err, 0);
        chk("rsp_req_ready", req_ready, 0);
    endtask

    task automatic finish_resp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ack_rsp_valid", rsp_valid, 0);
        chk("ack_req_ready", req_ready, 1);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        logic [127:0] r1;
        int tn;
        r1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        tick();
        tick();
        check_reset_vals();
        reset = 1'b1;
        init_window(1'b0);

        send_req(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0);
        core_reply(r1);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_text", rsp_text, r1);
            chk("stall_err", rsp_err, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        finish_resp();
        chk("sel_hold_idle", core_sel, 1);

        send_req(128'hdeadbeef_0badf00d_12345678_9abcdef0, 1'b0, 1'b0);
        tn = 0;
        for (int n = 1; n <= 300 && tn == 0; n++) begin
            tick();
            if (rsp_valid) tn = n;
        end
        chk("timeout_cycles", tn, 200);
        chk("timeout_err", rsp_err, 1);
        chk("timeout_text", rsp_text, 0);
        finish_resp();

        send_req(128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b1, 1'b0);
        core_reply(128'ha1a2a3a4_b1b2b3b4_c1c2c3c4_d1d2d3d4);
        finish_resp();

        send_req(128'hffeeddcc_bbaa9988_77665544_33221100, 1'b0, 1'b0);
        repeat (199) tick();
        chk("last_wait_no_rsp", rsp_valid, 0);
        core_reply(128'h11111111_22222222_33333333_44444444);
        finish_resp();

        send_req(128'h55555555_66666666_77777777_88888888, 1'b1, 1'b1);
        core_reply(128'h0f0f0f0f_f0f0f0f0_12121212_34343434);
        finish_resp();
        send_req(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc, 1'b0, 1'b1);
        core_reply(128'hcafebabe_feedface_8badf00d_c0ffee00);
        finish_resp();
        chk("sel_after_mode0", core_sel, 0);

        send_req(128'h13579bdf_2468ace0_fedcba98_76543210, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals();
        reset = 1'b1;
        init_window(1'b1);

        send_req(128'h0badcafe_0badcafe_0badcafe_0badcafe, 1'b1, 1'b0);
        core_reply(128'h76543210_fedcba98_01234567_89abcdef);
        finish_resp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
